// File: rtl/bju_if.sv
// Handshake and data bundle between the issue queue, the branch unit and writeback.
// The unit itself plugs in through the slave modport.
interface bju_if #(
  parameter int XLEN          = 64,
  parameter int PC_WIDTH      = 48,
  parameter int ROB_IDX_WIDTH = 7,
  parameter int CNT_WIDTH     = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [XLEN-1:0]          src1;
  logic [XLEN-1:0]          src2;
  logic [XLEN-1:0]          offset;
  logic [PC_WIDTH-1:0]      pc;
  logic [7:0]               cx_type;
  logic                     pred_taken;
  logic [PC_WIDTH-1:0]      pred_target;
  logic [ROB_IDX_WIDTH-1:0] rob_idx;
  logic                     flush;
  logic                     out_valid;
  logic                     out_ready;
  logic [XLEN-1:0]          out_dest;
  logic                     out_taken;
  logic [PC_WIDTH-1:0]      out_target;
  logic                     out_misalign;
  logic [ROB_IDX_WIDTH-1:0] out_rob_idx;
  logic                     redirect_valid;
  logic [PC_WIDTH-1:0]      redirect_target;
  logic [ROB_IDX_WIDTH-1:0] redirect_rob_idx;
  logic [CNT_WIDTH-1:0]     mispredict_cnt;

  modport slave (
    input  in_valid, src1, src2, offset, pc, cx_type, pred_taken, pred_target,
           rob_idx, flush, out_ready,
    output in_ready, out_valid, out_dest, out_taken, out_target, out_misalign,
           out_rob_idx, redirect_valid, redirect_target, redirect_rob_idx, mispredict_cnt
  );

  modport master (
    output in_valid, src1, src2, offset, pc, cx_type, pred_taken, pred_target,
           rob_idx, flush, out_ready,
    input  in_ready, out_valid, out_dest, out_taken, out_target, out_misalign,
           out_rob_idx, redirect_valid, redirect_target, redirect_rob_idx, mispredict_cnt
  );
endinterface

// File: rtl/bju_pipe.sv
// Two-stage branch/jump resolve unit: result 2 cycles after accept, 1 op/cycle, mispredict redirect pulse.
// A stalled out_ready holds S2 and backs up through S1 to in_ready; flush empties both stages.
module bju_pipe #(
  parameter int XLEN          = 64,
  parameter int PC_WIDTH      = 48,
  parameter int ROB_IDX_WIDTH = 7,
  parameter int CNT_WIDTH     = 16
) (
  input  logic clock,
  input  logic reset_n,
  bju_if.slave bus
);
  localparam int PW = PC_WIDTH;
  localparam int RW = ROB_IDX_WIDTH;

  logic s2_adv, s1_adv, in_fire, out_fire;
  logic eq, lt, ltu, cx_ok, taken;
  logic [7:0] cx;

  logic          s1_vld_q, s1_vld_d, s1_ok_q, s1_ok_d, s1_taken_q, s1_taken_d;
  logic          s1_pred_taken_q, s1_pred_taken_d;
  logic [PW-1:0] s1_target_q, s1_target_d, s1_seq_q, s1_seq_d;
  logic [PW-1:0] s1_pred_tgt_q, s1_pred_tgt_d;
  logic [RW-1:0] s1_rob_q, s1_rob_d;

  logic            s2_vld_q, s2_vld_d, s2_taken_q, s2_taken_d;
  logic            s2_misalign_q, s2_misalign_d, s2_mispred_q, s2_mispred_d;
  logic [XLEN-1:0] s2_dest_q, s2_dest_d;
  logic [PW-1:0]   s2_target_q, s2_target_d;
  logic [RW-1:0]   s2_rob_q, s2_rob_d;

  logic                 redirect_vld_q, redirect_vld_d;
  logic [PW-1:0]        redirect_target_q, redirect_target_d;
  logic [RW-1:0]        redirect_rob_q, redirect_rob_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

  always_comb begin
    s2_adv   = !s2_vld_q || bus.out_ready;
    s1_adv   = !s1_vld_q || s2_adv;
    in_fire  = bus.in_valid && s1_adv && !bus.flush;
    out_fire = s2_vld_q && bus.out_ready;

    cx    = bus.cx_type;
    cx_ok = (cx != 8'd0) && ((cx & (cx - 8'd1)) == 8'd0);
    eq    = bus.src1 == bus.src2;
    lt    = $signed(bus.src1) < $signed(bus.src2);
    ltu   = bus.src1 < bus.src2;
    taken = cx_ok && (cx[0] || cx[1] || (cx[2] && eq) || (cx[3] && !eq) ||
                      (cx[4] && lt) || (cx[5] && !lt) || (cx[6] && ltu) || (cx[7] && !ltu));

    s1_ok_d         = s1_ok_q;
    s1_taken_d      = s1_taken_q;
    s1_target_d     = s1_target_q;
    s1_seq_d        = s1_seq_q;
    s1_pred_taken_d = s1_pred_taken_q;
    s1_pred_tgt_d   = s1_pred_tgt_q;
    s1_rob_d        = s1_rob_q;
    if (in_fire) begin
      s1_ok_d         = cx_ok;
      s1_taken_d      = taken;
      s1_target_d     = (cx_ok && cx[1]) ? PW'((bus.src1 + bus.offset) & ~XLEN'(1))
                                         : PW'(XLEN'(bus.pc) + bus.offset);
      s1_seq_d        = bus.pc + PW'(4);
      s1_pred_taken_d = bus.pred_taken;
      s1_pred_tgt_d   = bus.pred_target;
      s1_rob_d        = bus.rob_idx;
    end
    s1_vld_d = bus.flush ? 1'b0 : (s1_adv ? in_fire : s1_vld_q);

    s2_dest_d     = s2_dest_q;
    s2_taken_d    = s2_taken_q;
    s2_target_d   = s2_target_q;
    s2_misalign_d = s2_misalign_q;
    s2_mispred_d  = s2_mispred_q;
    s2_rob_d      = s2_rob_q;
    if (s2_adv && s1_vld_q) begin
      s2_dest_d     = s1_ok_q ? XLEN'(s1_seq_q) : '0;
      s2_taken_d    = s1_taken_q;
      s2_target_d   = s1_taken_q ? s1_target_q : s1_seq_q;
      s2_misalign_d = s1_taken_q && (s1_target_q[1:0] != 2'b00);
      s2_mispred_d  = s1_ok_q && ((s1_taken_q != s1_pred_taken_q) ||
                                  (s1_taken_q && (s1_target_q != s1_pred_tgt_q)));
      s2_rob_d      = s1_rob_q;
    end
    s2_vld_d = bus.flush ? 1'b0 : (s2_adv ? s1_vld_q : s2_vld_q);

    // Redirect is armed by the output handshake itself, so a stalled op cannot fire it twice.
    redirect_vld_d    = out_fire && s2_mispred_q && !bus.flush;
    redirect_target_d = redirect_target_q;
    redirect_rob_d    = redirect_rob_q;
    cnt_d             = cnt_q;
    if (redirect_vld_d) begin
      redirect_target_d = s2_target_q;
      redirect_rob_d    = s2_rob_q;
      if (cnt_q != '1) cnt_d = cnt_q + CNT_WIDTH'(1);
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      s1_vld_q          <= 1'b0;
      s1_ok_q           <= 1'b0;
      s1_taken_q        <= 1'b0;
      s1_target_q       <= '0;
      s1_seq_q          <= '0;
      s1_pred_taken_q   <= 1'b0;
      s1_pred_tgt_q     <= '0;
      s1_rob_q          <= '0;
      s2_vld_q          <= 1'b0;
      s2_dest_q         <= '0;
      s2_taken_q        <= 1'b0;
      s2_target_q       <= '0;
      s2_misalign_q     <= 1'b0;
      s2_mispred_q      <= 1'b0;
      s2_rob_q          <= '0;
      redirect_vld_q    <= 1'b0;
      redirect_target_q <= '0;
      redirect_rob_q    <= '0;
      cnt_q             <= '0;
    end else begin
      s1_vld_q          <= s1_vld_d;
      s1_ok_q           <= s1_ok_d;
      s1_taken_q        <= s1_taken_d;
      s1_target_q       <= s1_target_d;
      s1_seq_q          <= s1_seq_d;
      s1_pred_taken_q   <= s1_pred_taken_d;
      s1_pred_tgt_q     <= s1_pred_tgt_d;
      s1_rob_q          <= s1_rob_d;
      s2_vld_q          <= s2_vld_d;
      s2_dest_q         <= s2_dest_d;
      s2_taken_q        <= s2_taken_d;
      s2_target_q       <= s2_target_d;
      s2_misalign_q     <= s2_misalign_d;
      s2_mispred_q      <= s2_mispred_d;
      s2_rob_q          <= s2_rob_d;
      redirect_vld_q    <= redirect_vld_d;
      redirect_target_q <= redirect_target_d;
      redirect_rob_q    <= redirect_rob_d;
      cnt_q             <= cnt_d;
    end
  end

  assign bus.in_ready         = s1_adv && !bus.flush;
  assign bus.out_valid        = s2_vld_q;
  assign bus.out_dest         = s2_dest_q;
  assign bus.out_taken        = s2_taken_q;
  assign bus.out_target       = s2_target_q;
  assign bus.out_misalign     = s2_misalign_q;
  assign bus.out_rob_idx      = s2_rob_q;
  assign bus.redirect_valid   = redirect_vld_q;
  assign bus.redirect_target  = redirect_target_q;
  assign bus.redirect_rob_idx = redirect_rob_q;
  assign bus.mispredict_cnt   = cnt_q;
endmodule

// File: tb/tb_bju_pipe.sv
// Bench for bju_pipe: directed vector table, stall/flush/saturation/reset sequences,
// with a result queue filled on accept and drained on output handshake.
module tb_bju_pipe;
  localparam int XLEN = 64;
  localparam int PW   = 48;
  localparam int RW   = 7;
  localparam int CW   = 4;

  typedef struct {
    logic [7:0]      cx;
    logic [XLEN-1:0] src1, src2, offset;
    logic [PW-1:0]   pc;
    logic            pt;
    logic [PW-1:0]   ptgt;
    logic [RW-1:0]   rob;
  } op_t;

  typedef struct {
    logic [XLEN-1:0] dest;
    logic            taken;
    logic [PW-1:0]   target;
    logic            misalign;
    logic            mispred;
    logic [RW-1:0]   rob;
  } exp_t;

  typedef struct {
    op_t  op;
    exp_t e;
  } vec_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  bju_if #(.XLEN(XLEN), .PC_WIDTH(PW), .ROB_IDX_WIDTH(RW), .CNT_WIDTH(CW)) bus ();

  bju_pipe #(.XLEN(XLEN), .PC_WIDTH(PW), .ROB_IDX_WIDTH(RW), .CNT_WIDTH(CW)) dut (
    .clock  (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  int n_chk = 0;
  int n_fail = 0;
  int n_acc = 0;
  exp_t q_exp[$];
  exp_t cur;
  logic exp_rv = 1'b0;
  logic nxt_rv;
  logic [PW-1:0] exp_rt;
  logic [RW-1:0] exp_rr;
  logic [CW-1:0] exp_cnt = '0;
  vec_t vecs[12];
  op_t  ops[4];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, req);
    end
  endtask

  function automatic op_t mk_op(input logic [7:0] cx, input logic [63:0] s1, input logic [63:0] s2,
                                input logic [63:0] off, input logic [47:0] pc, input logic pt,
                                input logic [47:0] ptgt, input logic [6:0] rob);
    op_t o;
    o.cx = cx; o.src1 = s1; o.src2 = s2; o.offset = off;
    o.pc = pc; o.pt = pt; o.ptgt = ptgt; o.rob = rob;
    return o;
  endfunction

  function automatic exp_t mk_exp(input logic [63:0] dest, input logic taken, input logic [47:0] tgt,
                                  input logic mis, input logic misp, input logic [6:0] rob);
    exp_t e;
    e.dest = dest; e.taken = taken; e.target = tgt;
    e.misalign = mis; e.mispred = misp; e.rob = rob;
    return e;
  endfunction

  // Reference behaviour written per opcode rather than as a sum of products.
  function automatic exp_t model(input op_t o);
    exp_t e;
    logic [63:0] sum;
    logic [PW-1:0] tgt, seq;
    logic tk, ok;
    seq = o.pc + 48'd4;
    sum = {16'h0, o.pc} + o.offset;
    tgt = sum[PW-1:0];
    ok  = 1'b1;
    tk  = 1'b0;
    case (o.cx)
      8'h01: tk = 1'b1;
      8'h02: begin
        tk  = 1'b1;
        sum = o.src1 + o.offset;
        tgt = {sum[PW-1:1], 1'b0};
      end
      8'h04: tk = (o.src1 == o.src2);
      8'h08: tk = (o.src1 != o.src2);
      8'h10: tk = ($signed(o.src1) < $signed(o.src2));
      8'h20: tk = ($signed(o.src1) >= $signed(o.src2));
      8'h40: tk = (o.src1 < o.src2);
      8'h80: tk = (o.src1 >= o.src2);
      default: ok = 1'b0;
    endcase
    e.taken    = tk;
    e.target   = tk ? tgt : seq;
    e.dest     = ok ? {16'h0, seq} : 64'h0;
    e.misalign = tk && (tgt[1:0] != 2'b00);
    e.mispred  = ok && ((tk != o.pt) || (tk && (tgt != o.ptgt)));
    e.rob      = o.rob;
    return e;
  endfunction

  function automatic op_t rnd_op(input logic [6:0] rob);
    op_t o;
    logic [63:0] off;
    o.cx     = 8'(1 << $urandom_range(7, 0));
    o.src1   = 64'($urandom_range(3, 0));
    o.src2   = 64'($urandom_range(3, 0));
    o.offset = 64'($urandom_range(63, 0)) << 2;
    o.pc     = 48'h9000 + (48'(rob) << 4);
    o.pt     = 1'($urandom_range(1, 0));
    off      = o.offset;
    o.ptgt   = o.pc + off[PW-1:0];
    o.rob    = rob;
    return o;
  endfunction

  task automatic send(input op_t o, input exp_t e);
    int n;
    bit ok;
    bus.in_valid = 1'b1;
    bus.cx_type = o.cx; bus.src1 = o.src1; bus.src2 = o.src2; bus.offset = o.offset;
    bus.pc = o.pc; bus.pred_taken = o.pt; bus.pred_target = o.ptgt; bus.rob_idx = o.rob;
    n = 0;
    ok = 1'b0;
    while (!ok && n < 50) begin
      @(negedge clk);
      if (bus.in_ready) ok = 1'b1;
      else n++;
    end
    if (ok) begin
      q_exp.push_back(e);
      n_acc++;
    end else begin
      n_chk++; n_fail++;
      $display("FAIL send_timeout: in_ready stuck 0 for rob %0d", o.rob);
    end
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (q_exp.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (q_exp.size() != 0) begin
      n_chk++; n_fail++;
      $display("FAIL drain_timeout: %0d results outstanding, 0 expected", q_exp.size());
    end
    repeat (2) @(posedge clk);
    #1;
  endtask

  // Output-side scoreboard: pops on handshake, checks held data and redirect pulses.
  always @(negedge clk) begin
    if (!reset_n) begin
      q_exp.delete();
      exp_rv  = 1'b0;
      exp_cnt = '0;
    end else begin
      if (exp_rv || bus.redirect_valid) begin
        chk("redirect_valid", bus.redirect_valid, exp_rv);
        if (exp_rv) begin
          chk("redirect_target", bus.redirect_target, exp_rt);
          chk("redirect_rob", bus.redirect_rob_idx, exp_rr);
        end
        chk("mispredict_cnt", bus.mispredict_cnt, exp_cnt);
      end
      nxt_rv = 1'b0;
      if (bus.flush) begin
        q_exp.delete();
      end else if (bus.out_valid) begin
        if (q_exp.size() == 0) begin
          n_chk++; n_fail++;
          $display("FAIL unexpected_out: rob %0d with no pending op", bus.out_rob_idx);
        end else if (bus.out_ready) begin
          cur = q_exp.pop_front();
          chk("out_rob", bus.out_rob_idx, cur.rob);
          chk("out_taken", bus.out_taken, cur.taken);
          chk("out_target", bus.out_target, cur.target);
          chk("out_dest", bus.out_dest, cur.dest);
          chk("out_misalign", bus.out_misalign, cur.misalign);
          if (cur.mispred) begin
            nxt_rv = 1'b1;
            exp_rt = cur.target;
            exp_rr = cur.rob;
            if (exp_cnt != '1) exp_cnt = exp_cnt + 1'b1;
          end
        end else begin
          chk("held_rob", bus.out_rob_idx, q_exp[0].rob);
          chk("held_target", bus.out_target, q_exp[0].target);
        end
      end
      exp_rv = nxt_rv;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{mk_op(8'h04, 64'd5, 64'd5, 64'h20, 48'h1000, 1'b0, 48'h0, 7'd1),
                 mk_exp(64'h1004, 1'b1, 48'h1020, 1'b0, 1'b1, 7'd1)};
    vecs[1]  = '{mk_op(8'h10, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 48'h1100, 1'b1, 48'h1140, 7'd2),
                 mk_exp(64'h1104, 1'b1, 48'h1140, 1'b0, 1'b0, 7'd2)};
    vecs[2]  = '{mk_op(8'h40, 64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 64'h40, 48'h1200, 1'b1, 48'h1240, 7'd3),
                 mk_exp(64'h1204, 1'b0, 48'h1204, 1'b0, 1'b1, 7'd3)};
    vecs[3]  = '{mk_op(8'h02, 64'h2001, 64'd0, 64'h10, 48'h3000, 1'b1, 48'h2010, 7'd4),
                 mk_exp(64'h3004, 1'b1, 48'h2010, 1'b0, 1'b0, 7'd4)};
    vecs[4]  = '{mk_op(8'h01, 64'd0, 64'd0, 64'h6, 48'h4000, 1'b1, 48'h4006, 7'd5),
                 mk_exp(64'h4004, 1'b1, 48'h4006, 1'b1, 1'b0, 7'd5)};
    vecs[5]  = '{mk_op(8'h08, 64'd7, 64'd7, 64'h100, 48'h5000, 1'b0, 48'h0, 7'd6),
                 mk_exp(64'h5004, 1'b0, 48'h5004, 1'b0, 1'b0, 7'd6)};
    vecs[6]  = '{mk_op(8'h20, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 48'h6000, 1'b1, 48'h5FF8, 7'd7),
                 mk_exp(64'h6004, 1'b0, 48'h6004, 1'b0, 1'b1, 7'd7)};
    vecs[7]  = '{mk_op(8'h80, 64'hFFFF_FFFF_FFFF_FFFB, 64'd3, 64'hFFFF_FFFF_FFFF_FFF8, 48'h6000, 1'b1, 48'h5FFC, 7'd8),
                 mk_exp(64'h6004, 1'b1, 48'h5FF8, 1'b0, 1'b1, 7'd8)};
    vecs[8]  = '{mk_op(8'h00, 64'd0, 64'd0, 64'h10, 48'h7000, 1'b1, 48'h7100, 7'd9),
                 mk_exp(64'h0, 1'b0, 48'h7004, 1'b0, 1'b0, 7'd9)};
    vecs[9]  = '{mk_op(8'h0C, 64'd1, 64'd1, 64'h10, 48'h7100, 1'b0, 48'h0, 7'd10),
                 mk_exp(64'h0, 1'b0, 48'h7104, 1'b0, 1'b0, 7'd10)};
    vecs[10] = '{mk_op(8'h01, 64'd0, 64'd0, 64'h8, 48'hFFFF_FFFF_FFFC, 1'b0, 48'h0, 7'd11),
                 mk_exp(64'h0, 1'b1, 48'h4, 1'b0, 1'b1, 7'd11)};
    vecs[11] = '{mk_op(8'h02, 64'h2003, 64'd0, 64'h0, 48'h3100, 1'b1, 48'h2002, 7'd12),
                 mk_exp(64'h3104, 1'b1, 48'h2002, 1'b1, 1'b0, 7'd12)};

    bus.in_valid = 1'b0; bus.flush = 1'b0; bus.out_ready = 1'b1;
    bus.cx_type = '0; bus.src1 = '0; bus.src2 = '0; bus.offset = '0;
    bus.pc = '0; bus.pred_taken = 1'b0; bus.pred_target = '0; bus.rob_idx = '0;

    #1;
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_redirect", bus.redirect_valid, 0);
    chk("rst_cnt", bus.mispredict_cnt, 0);
    chk("rst_out_target", bus.out_target, 0);
    chk("rst_out_dest", bus.out_dest, 0);
    #11 reset_n = 1'b1;
    @(posedge clk); #1;

    // Directed vectors, back-to-back at full throughput.
    for (int i = 0; i < 12; i++) send(vecs[i].op, vecs[i].e);
    drain();
    chk("cnt_after_table", bus.mispredict_cnt, 5);

    // Four ops against a 3-cycle output stall.
    for (int i = 0; i < 4; i++) ops[i] = rnd_op(7'(40 + i));
    ops[1].pt = ~model(ops[1]).taken;
    bus.out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send(ops[i], model(ops[i]));
      end
      begin
        int base;
        base = n_acc;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("stall_in_ready", bus.in_ready, 0);
        chk("stall_accepted", 64'(n_acc - base), 2);
        @(posedge clk); #1;
        bus.out_ready = 1'b1;
      end
    join
    drain();

    // Flush with both stages full and a new op presented.
    bus.out_ready = 1'b0;
    send(mk_op(8'h01, 0, 0, 64'h40, 48'hA000, 1'b0, 48'h0, 7'd60), model(mk_op(8'h01, 0, 0, 64'h40, 48'hA000, 1'b0, 48'h0, 7'd60)));
    send(mk_op(8'h01, 0, 0, 64'h40, 48'hA004, 1'b0, 48'h0, 7'd61), model(mk_op(8'h01, 0, 0, 64'h40, 48'hA004, 1'b0, 48'h0, 7'd61)));
    bus.flush = 1'b1; bus.in_valid = 1'b1; bus.out_ready = 1'b1;
    bus.cx_type = 8'h01; bus.pc = 48'hA008; bus.pred_taken = 1'b0; bus.rob_idx = 7'd62;
    @(negedge clk);
    chk("flush_in_ready", bus.in_ready, 0);
    chk("flush_cnt_before", bus.mispredict_cnt, exp_cnt);
    @(posedge clk); #1;
    bus.flush = 1'b0; bus.in_valid = 1'b0;
    chk("flush_out_valid", bus.out_valid, 0);
    @(posedge clk); #1;
    chk("flush_redirect", bus.redirect_valid, 0);
    chk("flush_cnt", bus.mispredict_cnt, exp_cnt);
    repeat (3) @(posedge clk); #1;
    chk("flush_drained", bus.out_valid, 0);

    // 19 mispredicts must pin the 4-bit counter at 15.
    for (int i = 0; i < 19; i++)
      send(mk_op(8'h01, 0, 0, 64'h100, 48'h8000 + 48'(i * 4), 1'b0, 48'h0, 7'(20 + i)),
           model(mk_op(8'h01, 0, 0, 64'h100, 48'h8000 + 48'(i * 4), 1'b0, 48'h0, 7'(20 + i))));
    drain();
    chk("cnt_saturated", bus.mispredict_cnt, 15);

    // Asynchronous reset with ops in flight.
    send(mk_op(8'h01, 0, 0, 64'h10, 48'hB000, 1'b0, 48'h0, 7'd70), model(mk_op(8'h01, 0, 0, 64'h10, 48'hB000, 1'b0, 48'h0, 7'd70)));
    send(mk_op(8'h04, 1, 1, 64'h10, 48'hB004, 1'b0, 48'h0, 7'd71), model(mk_op(8'h04, 1, 1, 64'h10, 48'hB004, 1'b0, 48'h0, 7'd71)));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_out_valid", bus.out_valid, 0);
    chk("arst_cnt", bus.mispredict_cnt, 0);
    chk("arst_redirect", bus.redirect_valid, 0);
    chk("arst_out_rob", bus.out_rob_idx, 0);
    #20 reset_n = 1'b1;
    repeat (3) @(posedge clk); #1;
    chk("post_arst_out_valid", bus.out_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
